// File: rtl/gate_apply_controller.sv
// gate_apply_controller
// Applies single-qubit gates to an internal state vector of 2^N_QUBITS complex
// amplitudes. An instruction is accepted over valid/ready, and its 2x2 complex
// matrix is fetched from gate_matrix_table. Every amplitude pair addressed by
// the target qubit is then updated, one pair per cycle, and done is pulsed.
// Amplitudes and matrix words are signed Q1.18 (W = 19 by default).

module gate_apply_controller #(
  parameter int N_QUBITS = 3,
  parameter int W        = 19
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init_state,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [4:0]             instr_gate,
  input  logic [2:0]             instr_target,
  output logic [4:0]             tbl_gate,
  output logic                   tbl_ready,
  input  logic                   tbl_done,
  input  logic signed [W-1:0]    tbl_result [0:1][0:1][0:1],
  output logic                   done,
  output logic                   err,
  input  logic [N_QUBITS-1:0]    rd_addr,
  output logic signed [W-1:0]    rd_real,
  output logic signed [W-1:0]    rd_imag
);

  localparam int NAMP  = 1 << N_QUBITS;
  localparam int NPAIR = NAMP / 2;
  localparam int FRAC  = W - 1;
  localparam int PW    = 2 * W;
  localparam int SW    = 2 * W + 2;

  // Largest positive Q1.18 value stands in for 1.0 in the |0> state
  localparam logic signed [W-1:0] AMP_ONE  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] AMP_MIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_APPLY,
    ST_FINISH
  } state_t;

  state_t                state;
  logic [2:0]            target_q;
  logic [N_QUBITS-1:0]   pair_cnt;
  logic signed [W-1:0]   mat [0:1][0:1][0:1];
  logic signed [W-1:0]   amp_re [NAMP];
  logic signed [W-1:0]   amp_im [NAMP];

  logic [N_QUBITS-1:0]   low_mask;
  logic [N_QUBITS-1:0]   idx0;
  logic [N_QUBITS-1:0]   idx1;
  logic signed [W-1:0]   a0r, a0i, a1r, a1i;
  logic signed [W-1:0]   n0r, n0i, n1r, n1i;

  // Full-precision signed product of a matrix word and an amplitude
  function automatic logic signed [PW-1:0] mul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  // Sign-extend a product to the accumulator width so four of them cannot overflow
  function automatic logic signed [SW-1:0] ext(input logic signed [PW-1:0] x);
    return SW'(x);
  endfunction

  // Floor-shift back to Q1.18, then clamp into the representable amplitude range
  function automatic logic signed [W-1:0] scale(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] sh;
    sh = s >>> FRAC;
    if ((&sh[SW-1:W-1]) || !(|sh[SW-1:W-1]))
      return sh[W-1:0];
    else if (sh[SW-1])
      return AMP_MIN;
    else
      return AMP_ONE;
  endfunction

  assign instr_ready = (state == ST_IDLE) && !init_state;

  // Pair addressing and the complex 2x2 matrix-vector product for the current pair
  always_comb begin
    low_mask = (N_QUBITS'(1) << target_q) - N_QUBITS'(1);
    idx0     = ((pair_cnt & ~low_mask) << 1) | (pair_cnt & low_mask);
    idx1     = idx0 | (N_QUBITS'(1) << target_q);
    a0r      = amp_re[idx0];
    a0i      = amp_im[idx0];
    a1r      = amp_re[idx1];
    a1i      = amp_im[idx1];
    n0r = scale(ext(mul(mat[0][0][0], a0r)) - ext(mul(mat[0][0][1], a0i))
              + ext(mul(mat[0][1][0], a1r)) - ext(mul(mat[0][1][1], a1i)));
    n0i = scale(ext(mul(mat[0][0][0], a0i)) + ext(mul(mat[0][0][1], a0r))
              + ext(mul(mat[0][1][0], a1i)) + ext(mul(mat[0][1][1], a1r)));
    n1r = scale(ext(mul(mat[1][0][0], a0r)) - ext(mul(mat[1][0][1], a0i))
              + ext(mul(mat[1][1][0], a1r)) - ext(mul(mat[1][1][1], a1i)));
    n1i = scale(ext(mul(mat[1][0][0], a0i)) + ext(mul(mat[1][0][1], a0r))
              + ext(mul(mat[1][1][0], a1i)) + ext(mul(mat[1][1][1], a1r)));
  end

  // Instruction sequencer: owns the state vector, matrix latch and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      target_q  <= '0;
      pair_cnt  <= '0;
      tbl_gate  <= '0;
      tbl_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          for (int k = 0; k < 2; k++)
            mat[r][c][k] <= '0;
      for (int i = 0; i < NAMP; i++) begin
        amp_re[i] <= (i == 0) ? AMP_ONE : '0;
        amp_im[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (init_state) begin
            for (int i = 0; i < NAMP; i++) begin
              amp_re[i] <= (i == 0) ? AMP_ONE : '0;
              amp_im[i] <= '0;
            end
          end else if (instr_valid) begin
            if (int'(instr_target) < N_QUBITS) begin
              target_q  <= instr_target;
              tbl_gate  <= instr_gate;
              tbl_ready <= 1'b1;
              state     <= ST_FETCH;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ST_FINISH;
            end
          end
        end
        ST_FETCH: begin
          if (tbl_done) begin
            mat       <= tbl_result;
            pair_cnt  <= '0;
            tbl_ready <= 1'b0;
            state     <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          amp_re[idx0] <= n0r;
          amp_im[idx0] <= n0i;
          amp_re[idx1] <= n1r;
          amp_im[idx1] <= n1i;
          pair_cnt     <= pair_cnt + N_QUBITS'(1);
          if (pair_cnt == N_QUBITS'(NPAIR - 1)) begin
            done  <= 1'b1;
            err   <= 1'b0;
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered amplitude readout, live in every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_real <= '0;
      rd_imag <= '0;
    end else begin
      rd_real <= amp_re[rd_addr];
      rd_imag <= amp_im[rd_addr];
    end
  end

endmodule

// File: tb/tb_gate_apply_controller.sv
// Directed bench for gate_apply_controller (N_QUBITS = 3, W = 19).
// Plays the part of gate_matrix_table and checks handshake timing and the
// resulting state vector against hand-computed Q1.18 values.

module tb_gate_apply_controller;

  localparam int W = 19;
  localparam int NQ = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 init_state;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [4:0]           instr_gate;
  logic [2:0]           instr_target;
  logic [4:0]           tbl_gate;
  logic                 tbl_ready;
  logic                 tbl_done;
  logic signed [W-1:0]  tbl_result [0:1][0:1][0:1];
  logic                 done;
  logic                 err;
  logic [NQ-1:0]        rd_addr;
  logic signed [W-1:0]  rd_real;
  logic signed [W-1:0]  rd_imag;

  int checks = 0;
  int failures = 0;
  int exp_re [8];
  int exp_im [8];

  gate_apply_controller #(.N_QUBITS(NQ), .W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .init_state   (init_state),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_gate   (instr_gate),
    .instr_target (instr_target),
    .tbl_gate     (tbl_gate),
    .tbl_ready    (tbl_ready),
    .tbl_done     (tbl_done),
    .tbl_result   (tbl_result),
    .done         (done),
    .err          (err),
    .rd_addr      (rd_addr),
    .rd_real      (rd_real),
    .rd_imag      (rd_imag)
  );

  always #5 clk = ~clk;

  // Safety net so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic setEntry(input int r, input int c, input int re, input int im);
    tbl_result[r][c][0] = W'(re);
    tbl_result[r][c][1] = W'(im);
  endtask

  // Matrix table model: 0 = H, 2 = saturating test matrix, 3 = 0.5i * identity
  task automatic setMatrix(input int g);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        setEntry(r, c, 0, 0);
    case (g)
      0: begin
        setEntry(0, 0, 185363, 0); setEntry(0, 1, 185363, 0);
        setEntry(1, 0, 185363, 0); setEntry(1, 1, -185363, 0);
      end
      2: begin
        setEntry(0, 0, 262143, 0);  setEntry(0, 1, 262143, 0);
        setEntry(1, 0, -262144, 0); setEntry(1, 1, -262144, 0);
      end
      3: begin
        setEntry(0, 0, 0, 131072); setEntry(1, 1, 0, 131072);
      end
      default: ;
    endcase
  endtask

  task automatic clearExp();
    for (int i = 0; i < 8; i++) begin
      exp_re[i] = 0;
      exp_im[i] = 0;
    end
  endtask

  task automatic sweepState(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      tick();
      checkOutput($sformatf("%s re[%0d]", tag, i), rd_real, exp_re[i]);
      checkOutput($sformatf("%s im[%0d]", tag, i), rd_imag, exp_im[i]);
    end
  endtask

  // Offer one instruction, answer the fetch after fetch_delay cycles, check timing
  task automatic applyStimulus(input int gate, input int target, input int fetch_delay,
                               input int exp_latency, input bit busy_valid);
    int cyc;
    setMatrix(gate);
    instr_gate   = 5'(gate);
    instr_target = 3'(target);
    instr_valid  = 1'b1;
    #1;
    checkOutput("accept ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    cyc = 1;
    if (target >= NQ) begin
      checkOutput("illegal done", done, 1);
      checkOutput("illegal err", err, 1);
      checkOutput("illegal tbl_ready", tbl_ready, 0);
      checkOutput("illegal busy", instr_ready, 0);
      tick();
      checkOutput("illegal done width", done, 0);
      checkOutput("illegal tbl_ready late", tbl_ready, 0);
      checkOutput("illegal ready back", instr_ready, 1);
      return;
    end
    for (int k = 1; k <= fetch_delay; k++) begin
      checkOutput("fetch tbl_ready", tbl_ready, 1);
      checkOutput("fetch tbl_gate", tbl_gate, gate);
      checkOutput("fetch busy", instr_ready, 0);
      tbl_done    = (k == fetch_delay);
      instr_valid = busy_valid;
      tick();
      cyc++;
    end
    tbl_done = 1'b0;
    while (done !== 1'b1 && cyc < 64) begin
      checkOutput("apply busy", instr_ready, 0);
      checkOutput("apply tbl_ready", tbl_ready, 0);
      instr_valid = busy_valid;
      tick();
      cyc++;
    end
    instr_valid = 1'b0;
    checkOutput("done latency", cyc, exp_latency);
    checkOutput("done err", err, 0);
    checkOutput("finish busy", instr_ready, 0);
    tick();
    checkOutput("done width", done, 0);
    checkOutput("ready back", instr_ready, 1);
  endtask

  initial begin
    reset        = 1'b1;
    init_state   = 1'b0;
    instr_valid  = 1'b0;
    instr_gate   = '0;
    instr_target = '0;
    tbl_done     = 1'b0;
    rd_addr      = '0;
    setMatrix(0);

    // Reset values
    #12;
    checkOutput("reset instr_ready", instr_ready, 1);
    checkOutput("reset tbl_ready", tbl_ready, 0);
    checkOutput("reset tbl_gate", tbl_gate, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset rd_real", rd_real, 0);
    checkOutput("reset rd_imag", rd_imag, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    clearExp();
    exp_re[0] = 262143;
    sweepState("after reset");

    // H on qubit 0, table answers on the third FETCH cycle: done at T+8
    applyStimulus(0, 0, 3, 8, 1'b0);
    exp_re[0] = 185362;
    exp_re[1] = 185362;
    sweepState("H t0");

    // Second H on qubit 0 returns almost to |0>
    applyStimulus(0, 0, 2, 7, 1'b0);
    exp_re[0] = 262140;
    exp_re[1] = 0;
    sweepState("HH t0");

    // init_state wins over instr_valid; the instruction goes in one cycle later
    init_state   = 1'b1;
    instr_valid  = 1'b1;
    instr_gate   = 5'd0;
    instr_target = 3'd2;
    #1;
    checkOutput("init blocks ready", instr_ready, 0);
    tick();
    init_state = 1'b0;
    checkOutput("init no accept", tbl_ready, 0);
    applyStimulus(0, 2, 1, 6, 1'b1);
    clearExp();
    exp_re[0] = 185362;
    exp_re[4] = 185362;
    sweepState("init H t2");

    // Illegal target: immediate done/err, no fetch, state untouched
    applyStimulus(7, 5, 0, 0, 1'b0);
    sweepState("illegal");

    // Saturation in both directions, slow table answer
    applyStimulus(2, 2, 5, 10, 1'b0);
    exp_re[0] = 262143;
    exp_re[4] = -262144;
    sweepState("saturate");

    // Purely imaginary matrix exercises the cross terms
    applyStimulus(3, 2, 1, 6, 1'b0);
    clearExp();
    exp_im[0] = 131071;
    exp_im[4] = -131072;
    sweepState("imag once");

    applyStimulus(3, 2, 1, 6, 1'b0);
    clearExp();
    exp_re[0] = -65536;
    exp_re[4] = 65536;
    sweepState("imag twice");

    // Reset in the middle of APPLY
    rd_addr      = 3'd4;
    setMatrix(0);
    instr_gate   = 5'd0;
    instr_target = 3'd1;
    instr_valid  = 1'b1;
    tick();
    instr_valid = 1'b0;
    checkOutput("pre-reset fetch", tbl_ready, 1);
    tbl_done = 1'b1;
    tick();
    tbl_done = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset instr_ready", instr_ready, 1);
    checkOutput("midreset tbl_ready", tbl_ready, 0);
    checkOutput("midreset tbl_gate", tbl_gate, 0);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset err", err, 0);
    checkOutput("midreset rd_real", rd_real, 0);
    checkOutput("midreset rd_imag", rd_imag, 0);
    #2;
    reset = 1'b0;
    tick();
    clearExp();
    exp_re[0] = 262143;
    sweepState("after midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
